// File: rtl/keypad_digit_loader.sv
// Keypad front end for the countdown timer: sync, debounce, BCD-encode, one load per press.
// Latency: key stable from edge 1 -> loadn low in the cycle after edge 3+DEBOUNCE_CYCLES.
// Backpressure: presses ignored while entry_en is low or the digit count is full; held keys load once.
//
// Ports:
//   clk          system clock, rising edge
//   clrn         asynchronous active-low reset
//   keys[9:0]    raw key lines (bit i = key i), asynchronous to clk
//   entry_en     high allows new presses (timer stopped)
//   digit_clr    synchronous clear of digit_count; aborts a press being debounced
//   data[3:0]    BCD code of the last loaded key
//   loadn        active-low one-cycle load strobe to the timer
//   digit_count  digits loaded since last clear, saturates at MAX_DIGITS
//   full         digit_count == MAX_DIGITS
module keypad_digit_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [9:0] keys,
  input  logic       entry_en,
  input  logic       digit_clr,
  output logic [3:0] data,
  output logic       loadn,
  output logic [1:0] digit_count,
  output logic       full
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      MAX_CNT  = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_LOAD,
    S_RELEASE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_sync1, r_sync2;
  logic [9:0]    r_pat, w_pat_nxt;
  logic [3:0]    r_code, w_code_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_data;
  logic          r_loadn;
  logic [1:0]    r_count, w_count_nxt;
  logic          w_single;
  logic [3:0]    w_code;

  // Exactly one key down; anything else (none or chords) is not a press.
  assign w_single = ($countones(r_sync2) == 1);

  always_comb begin
    w_code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_sync2[i]) w_code = 4'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (entry_en && w_single && !full) begin
          w_state_nxt = S_DEBOUNCE;
          w_pat_nxt   = r_sync2;
          w_code_nxt  = w_code;
          w_cnt_nxt   = '0;
        end
      end
      S_DEBOUNCE: begin
        // Cancel wins: the key must be released before it can be pressed again.
        if (digit_clr)                            w_state_nxt = S_RELEASE;
        else if (r_sync2 != r_pat || !entry_en)   w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_LAST)               w_state_nxt = S_LOAD;
        else                                      w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_LOAD:    w_state_nxt = S_RELEASE;
      S_RELEASE: if (r_sync2 == '0) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (digit_clr)                                 w_count_nxt = '0;
    else if (r_state == S_LOAD && r_count != MAX_CNT) w_count_nxt = r_count + 2'd1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_code  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_loadn <= 1'b1;
      r_count <= '0;
    end else begin
      r_sync1 <= keys;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_code  <= w_code_nxt;
      r_cnt   <= w_cnt_nxt;
      // Strobe comes straight from a flop so the timer never sees a decode glitch.
      r_loadn <= (w_state_nxt != S_LOAD);
      if (w_state_nxt == S_LOAD) r_data <= r_code;
      r_count <= w_count_nxt;
    end
  end

  assign data        = r_data;
  assign loadn       = r_loadn;
  assign digit_count = r_count;
  assign full        = (r_count == MAX_CNT);

endmodule

// File: tb/tb_keypad_digit_loader.sv
// Bench for keypad_digit_loader: directed segment table, hand-written corner sequences,
// and randomized bursts compared every cycle against a press-level reference model.
module tb_keypad_digit_loader;

  localparam int D   = 4;
  localparam int MAX = 3;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic [9:0] keys = '0;
  logic       entry_en = 1'b1;
  logic       digit_clr = 1'b0;
  logic [3:0] data;
  logic       loadn;
  logic [1:0] digit_count;
  logic       full;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  keypad_digit_loader #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(MAX)) dut (
    .clk(clk), .clrn(clrn), .keys(keys), .entry_en(entry_en), .digit_clr(digit_clr),
    .data(data), .loadn(loadn), .digit_count(digit_count), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] k(input int n);
    logic [9:0] one;
    one = 10'd1;
    return one << n;
  endfunction

  function automatic int key_index(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A press is accepted when, starting from an armed and not-full keypad, the same single
  // key is seen with entry enabled on D+1 consecutive sampled edges; the strobe then
  // lasts one cycle, and the keypad re-arms only after an all-released sample.
  logic [9:0] m_s1 = '0, m_s2 = '0, m_pat = '0;
  bit         m_armed = 1'b1;
  bit         m_loading = 1'b0;
  int         m_streak = 0;
  int         m_count = 0;
  int         m_data = 0;

  always @(posedge clk or negedge clrn) begin
    logic [9:0] ks;
    bit was_full;
    if (!clrn) begin
      m_s1 = '0; m_s2 = '0; m_pat = '0;
      m_armed = 1'b1; m_loading = 1'b0; m_streak = 0; m_count = 0; m_data = 0;
    end else begin
      ks = m_s2;
      was_full = (m_count == MAX);
      if (m_loading) begin
        m_loading = 1'b0;
        m_armed = 1'b0;
        if (digit_clr) m_count = 0;
        else if (m_count < MAX) m_count = m_count + 1;
      end else if (!m_armed) begin
        if (digit_clr) m_count = 0;
        if (ks == '0) m_armed = 1'b1;
      end else if (m_streak == 0) begin
        if (digit_clr) m_count = 0;
        if (entry_en && $countones(ks) == 1 && !was_full) begin
          m_streak = 1;
          m_pat = ks;
        end
      end else begin
        if (digit_clr) begin
          m_count = 0; m_streak = 0; m_armed = 1'b0;
        end else if (ks != m_pat || !entry_en) begin
          m_streak = 0;
        end else if (m_streak == D) begin
          m_loading = 1'b1; m_streak = 0; m_data = key_index(m_pat);
        end else begin
          m_streak = m_streak + 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = keys;
    end
  end

  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      checks++;
      if (loadn !== !m_loading || int'(data) != m_data || int'(digit_count) != m_count ||
          full !== (m_count == MAX)) begin
        errors++;
        $display("FAIL model t=%0t: got loadn=%b data=%0d cnt=%0d full=%b expected loadn=%b data=%0d cnt=%0d full=%b",
                 $time, loadn, data, digit_count, full, !m_loading, m_data, m_count, (m_count == MAX));
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Called at a negedge; drives inputs, holds them n cycles, counts strobe cycles.
  task automatic apply(input logic [9:0] kv, input logic en, input logic clr, input int n,
                       output int pulses, output int first);
    keys = kv; entry_en = en; digit_clr = clr;
    pulses = 0; first = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (loadn == 1'b0) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  typedef struct {
    logic [9:0] kv;
    logic       en;
    logic       clr;
    int         n;
    int         exp_pulses;
    int         exp_first;
    int         exp_data;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [9:0] kv, input logic en, input logic clr, input int n,
                     input int p, input int f, input int dt, input int c);
    vec_t v;
    v.kv = kv; v.en = en; v.clr = clr; v.n = n;
    v.exp_pulses = p; v.exp_first = f; v.exp_data = dt; v.exp_cnt = c;
    tbl.push_back(v);
  endtask

  task automatic seg(input string nm, input logic [9:0] kv, input int n,
                     input int p, input int f, input int dt, input int c);
    int pulses, first;
    apply(kv, 1'b1, 1'b0, n, pulses, first);
    chk({nm, " pulses"}, pulses, p);
    chk({nm, " first"}, first, f);
    chk({nm, " data"}, int'(data), dt);
    chk({nm, " count"}, int'(digit_count), c);
  endtask

  initial begin
    int pulses, first;
    logic [9:0] kv;
    bit en;
    int r, a, b, n;

    #1 clrn = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst data", int'(data), 0);
    chk("rst loadn", int'(loadn), 1);
    chk("rst count", int'(digit_count), 0);
    chk("rst full", int'(full), 0);
    clrn = 1'b1;

    // bounce, chord, single press, clear, 1-2-3-4 saturation, entry_en gating
    add(k(7),        1, 0, 2,  0, 0, 0, 0);
    add('0,          1, 0, 8,  0, 0, 0, 0);
    add(k(3) | k(8), 1, 0, 10, 0, 0, 0, 0);
    add('0,          1, 0, 4,  0, 0, 0, 0);
    add(k(5),        1, 0, 20, 1, 7, 5, 1);
    add('0,          1, 0, 4,  0, 0, 5, 1);
    add('0,          1, 1, 2,  0, 0, 5, 0);
    add(k(1),        1, 0, 10, 1, 7, 1, 1);
    add('0,          1, 0, 4,  0, 0, 1, 1);
    add(k(2),        1, 0, 10, 1, 7, 2, 2);
    add('0,          1, 0, 4,  0, 0, 2, 2);
    add(k(3),        1, 0, 10, 1, 7, 3, 3);
    add('0,          1, 0, 4,  0, 0, 3, 3);
    add(k(4),        1, 0, 12, 0, 0, 3, 3);
    add('0,          1, 0, 4,  0, 0, 3, 3);
    add('0,          1, 1, 2,  0, 0, 3, 0);
    add(k(9),        0, 0, 10, 0, 0, 3, 0);
    add(k(9),        1, 0, 12, 1, 5, 9, 1);
    add('0,          1, 0, 4,  0, 0, 9, 1);

    foreach (tbl[i]) begin
      apply(tbl[i].kv, tbl[i].en, tbl[i].clr, tbl[i].n, pulses, first);
      chk($sformatf("vec%0d pulses", i), pulses, tbl[i].exp_pulses);
      chk($sformatf("vec%0d first", i), first, tbl[i].exp_first);
      chk($sformatf("vec%0d data", i), int'(data), tbl[i].exp_data);
      chk($sformatf("vec%0d count", i), int'(digit_count), tbl[i].exp_cnt);
      chk($sformatf("vec%0d full", i), int'(full), int'(tbl[i].exp_cnt == MAX));
    end

    // digit_clr coincident with the LOAD cycle at count 2
    seg("pre8", k(8), 10, 1, 7, 8, 2);
    seg("rel8", '0, 4, 0, 0, 8, 2);
    keys = k(1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 7) begin
        chk("clrload loadn", int'(loadn), 0);
        digit_clr = 1'b1;
      end
      if (i == 8) begin
        digit_clr = 1'b0;
        chk("clrload count", int'(digit_count), 0);
        chk("clrload full", int'(full), 0);
        chk("clrload loadn after", int'(loadn), 1);
        chk("clrload data", int'(data), 1);
      end
    end
    seg("rel1", '0, 4, 0, 0, 1, 0);
    seg("pre3", k(3), 10, 1, 7, 3, 1);
    seg("rel3", '0, 4, 0, 0, 3, 1);

    // reset in the middle of debouncing key 6
    keys = k(6);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("midrst loadn before", int'(loadn), 1);
    clrn = 1'b0;
    #1;
    chk("midrst data", int'(data), 0);
    chk("midrst loadn", int'(loadn), 1);
    chk("midrst count", int'(digit_count), 0);
    chk("midrst full", int'(full), 0);
    keys = '0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    seg("postrst quiet", '0, 15, 0, 0, 0, 0);
    seg("postrst key6", k(6), 10, 1, 7, 6, 1);
    seg("postrst rel", '0, 4, 0, 0, 6, 1);

    // randomized bursts, checked every cycle by the model
    for (int burst = 0; burst < 400; burst++) begin
      r = $urandom_range(0, 9);
      if (r < 3) kv = '0;
      else if (r < 8) kv = k($urandom_range(0, 9));
      else begin
        a = $urandom_range(0, 9);
        b = (a + 1 + $urandom_range(0, 8)) % 10;
        kv = k(a) | k(b);
      end
      en = ($urandom_range(0, 9) != 0);
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        keys = kv;
        entry_en = en;
        digit_clr = ($urandom_range(0, 14) == 0);
        @(negedge clk);
      end
    end
    keys = '0; entry_en = 1'b1; digit_clr = 1'b0;
    repeat (6) @(negedge clk);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
